// File: rtl/load_data_extractor.sv
// load_data_extractor: MEM-stage load unit. Issues one data-memory read per
// accepted load, waits for the ack, selects the addressed byte/halfword/word,
// zero- or sign-extends it, and holds the result under a valid/ready handshake.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   - misaligned halfword/word loads complete in HOLD with
//               misaligned=1, wb_data=0 and no memory access.
//   undefined - misaligned is 0; low offset bits are ignored for halfword
//               (addr_low[0]) and word (addr_low[1:0]) loads.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid/req_ready         load request handshake (req_ready combinational)
//   addr_low, load_size,
//   extension_type, dest_reg    load attributes, latched on accept
//   mem_req/mem_ack/mem_rdata   data-memory read port
//   wb_valid/wb_ready           result handshake
//   wb_data, wb_dest            extracted data and destination register
//   misaligned, bus_error       status, qualified by wb_valid
module load_data_extractor #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  addr_low,
  input  logic [1:0]  load_size,
  input  logic [1:0]  extension_type,
  input  logic [4:0]  dest_reg,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_dest,
  output logic        misaligned,
  output logic        bus_error
);

  localparam int unsigned DATA_W = 32;
  // Last counter value of a WAIT_MEM window; reaching it without ack times out.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    HOLD     = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic [1:0]          ext_q, ext_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [4:0]          wb_dest_q, wb_dest_d;
  logic                mis_q, mis_d;
  logic                berr_q, berr_d;

  logic                accept_c;
  logic                mis_c;
  logic [7:0]          byte_c;
  logic [15:0]         half_c;
  logic                sign_c;
  logic [DATA_W-1:0]   ext_data_c;

  assign req_ready = (state_q == IDLE) | ((state_q == HOLD) & wb_ready);
  assign accept_c  = req_valid & req_ready;

  // Misalignment check on the incoming request (size 11 behaves as word).
`ifdef MISALIGN_TRAP_EN
  assign mis_c = ((load_size == 2'b01) & addr_low[0]) |
                 (load_size[1] & (addr_low != 2'b00));
`else
  assign mis_c = 1'b0;
`endif

  // Lane selection and extension from the latched attributes.
  always_comb begin
    byte_c = mem_rdata[7:0];
    case (addr_q)
      2'd1:    byte_c = mem_rdata[15:8];
      2'd2:    byte_c = mem_rdata[23:16];
      2'd3:    byte_c = mem_rdata[31:24];
      default: byte_c = mem_rdata[7:0];
    endcase
    half_c = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    sign_c = (ext_q == 2'b01);
    case (size_q)
      2'b00:   ext_data_c = {{24{sign_c & byte_c[7]}}, byte_c};
      2'b01:   ext_data_c = {{16{sign_c & half_c[15]}}, half_c};
      default: ext_data_c = mem_rdata;
    endcase
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    ext_d      = ext_q;
    cnt_d      = cnt_q;
    mem_req_d  = mem_req_q;
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_dest_d  = wb_dest_q;
    mis_d      = mis_q;
    berr_d     = berr_q;

    case (state_q)
      WAIT_MEM: begin
        if (mem_ack) begin
          state_d    = HOLD;
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_data_d  = ext_data_c;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = HOLD;
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_data_d  = '0;
          berr_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      HOLD: begin
        if (wb_ready & ~req_valid) begin
          state_d    = IDLE;
          wb_valid_d = 1'b0;
          mis_d      = 1'b0;
          berr_d     = 1'b0;
        end
      end
      default: ;
    endcase

    // Accept overrides IDLE/HOLD behaviour; it is never true in WAIT_MEM.
    if (accept_c) begin
      addr_d    = addr_low;
      size_d    = load_size;
      ext_d     = extension_type;
      wb_dest_d = dest_reg;
      cnt_d     = '0;
      berr_d    = 1'b0;
      if (mis_c) begin
        state_d    = HOLD;
        mem_req_d  = 1'b0;
        wb_valid_d = 1'b1;
        wb_data_d  = '0;
        mis_d      = 1'b1;
      end else begin
        state_d    = WAIT_MEM;
        mem_req_d  = 1'b1;
        wb_valid_d = 1'b0;
        mis_d      = 1'b0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      ext_q      <= '0;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_dest_q  <= '0;
      mis_q      <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      ext_q      <= ext_d;
      cnt_q      <= cnt_d;
      mem_req_q  <= mem_req_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_dest_q  <= wb_dest_d;
      mis_q      <= mis_d;
      berr_q     <= berr_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_data_q;
  assign wb_dest    = wb_dest_q;
  assign misaligned = mis_q;
  assign bus_error  = berr_q;

endmodule

// File: tb/tb_load_data_extractor.sv
// Directed testbench for load_data_extractor (TIMEOUT_CYCLES=4).
module tb_load_data_extractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  addr_low = 2'd0;
  logic [1:0]  load_size = 2'd0;
  logic [1:0]  extension_type = 2'd0;
  logic [4:0]  dest_reg = 5'd0;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [31:0] wb_data;
  logic [4:0]  wb_dest;
  logic        misaligned;
  logic        bus_error;

  int total = 0;
  int bad = 0;

  load_data_extractor #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .addr_low(addr_low), .load_size(load_size),
    .extension_type(extension_type), .dest_reg(dest_reg),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_dest(wb_dest),
    .misaligned(misaligned), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] sz, input logic [1:0] a,
                       input logic [1:0] ext, input logic [4:0] d);
    req_valid = 1'b1; load_size = sz; addr_low = a;
    extension_type = ext; dest_reg = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic ack_after(input int n, input logic [31:0] data);
    repeat (n) tick();
    mem_rdata = data; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic release_wb();
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    total++; if ({mem_req, wb_valid, misaligned, bus_error} !== 4'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {mem_req, wb_valid, misaligned, bus_error}); end
    total++; if (wb_data !== 32'h0 || wb_dest !== 5'h0) begin
      bad++; $display("FAIL reset_data got=%h/%h exp=0/0", wb_data, wb_dest); end
    rst = 1'b0;
    tick();
    total++; if (req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_sign_byte();
    issue(2'b00, 2'd2, 2'b01, 5'd7);
    total++; if (mem_req !== 1'b1) begin
      bad++; $display("FAIL sbyte_memreq got=%b exp=1", mem_req); end
    // Ack arrives in the last cycle of the timeout window: ack must win.
    repeat (3) tick();
    total++; if (mem_req !== 1'b1 || wb_valid !== 1'b0) begin
      bad++; $display("FAIL sbyte_wait got=%b%b exp=10", mem_req, wb_valid); end
    ack_after(0, 32'h1285_3456);
    total++; if (wb_valid !== 1'b1 || mem_req !== 1'b0 || bus_error !== 1'b0) begin
      bad++; $display("FAIL sbyte_flags got=%b%b%b exp=100", wb_valid, mem_req, bus_error); end
    total++; if (wb_data !== 32'hFFFF_FF85) begin
      bad++; $display("FAIL sbyte_data got=%h exp=ffffff85", wb_data); end
    total++; if (wb_dest !== 5'd7) begin
      bad++; $display("FAIL sbyte_dest got=%0d exp=7", wb_dest); end
    release_wb();
    total++; if (wb_valid !== 1'b0) begin
      bad++; $display("FAIL sbyte_release got=%b exp=0", wb_valid); end
  endtask

  task automatic test_extract();
    issue(2'b01, 2'd2, 2'b00, 5'd1);
    ack_after(1, 32'h8001_7FFF);
    total++; if (wb_data !== 32'h0000_8001) begin
      bad++; $display("FAIL zhalf_data got=%h exp=00008001", wb_data); end
    release_wb();
    issue(2'b01, 2'd2, 2'b01, 5'd2);
    ack_after(0, 32'h8001_7FFF);
    total++; if (wb_data !== 32'hFFFF_8001) begin
      bad++; $display("FAIL shalf_data got=%h exp=ffff8001", wb_data); end
    release_wb();
    issue(2'b01, 2'd0, 2'b01, 5'd3);
    ack_after(0, 32'h8001_7FFF);
    total++; if (wb_data !== 32'h0000_7FFF) begin
      bad++; $display("FAIL shalf_lo_data got=%h exp=00007fff", wb_data); end
    release_wb();
    issue(2'b00, 2'd0, 2'b00, 5'd4);
    ack_after(0, 32'h1285_34F6);
    total++; if (wb_data !== 32'h0000_00F6) begin
      bad++; $display("FAIL zbyte_data got=%h exp=000000f6", wb_data); end
    release_wb();
    issue(2'b11, 2'd0, 2'b01, 5'd5);
    ack_after(0, 32'hCAFE_F00D);
    total++; if (wb_data !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL word11_data got=%h exp=cafef00d", wb_data); end
    release_wb();
  endtask

  task automatic test_misaligned();
    issue(2'b10, 2'd1, 2'b00, 5'd6);
`ifdef MISALIGN_TRAP_EN
    total++; if (mem_req !== 1'b0 || wb_valid !== 1'b1 || misaligned !== 1'b1) begin
      bad++; $display("FAIL mis_flags got=%b%b%b exp=011", mem_req, wb_valid, misaligned); end
    total++; if (wb_data !== 32'h0 || wb_dest !== 5'd6) begin
      bad++; $display("FAIL mis_data got=%h/%0d exp=0/6", wb_data, wb_dest); end
    tick();
    total++; if (mem_req !== 1'b0 || misaligned !== 1'b1) begin
      bad++; $display("FAIL mis_hold got=%b%b exp=01", mem_req, misaligned); end
    release_wb();
    total++; if (misaligned !== 1'b0 || wb_valid !== 1'b0) begin
      bad++; $display("FAIL mis_clear got=%b%b exp=00", misaligned, wb_valid); end
`else
    total++; if (mem_req !== 1'b1) begin
      bad++; $display("FAIL mis_memreq got=%b exp=1", mem_req); end
    ack_after(0, 32'hDEAD_BEEF);
    total++; if (wb_data !== 32'hDEAD_BEEF || misaligned !== 1'b0) begin
      bad++; $display("FAIL mis_word got=%h/%b exp=deadbeef/0", wb_data, misaligned); end
    release_wb();
    issue(2'b01, 2'd3, 2'b00, 5'd6);
    ack_after(0, 32'hABCD_1234);
    total++; if (wb_data !== 32'h0000_ABCD || misaligned !== 1'b0) begin
      bad++; $display("FAIL mis_half got=%h/%b exp=0000abcd/0", wb_data, misaligned); end
    release_wb();
`endif
  endtask

  task automatic test_timeout();
    issue(2'b10, 2'd0, 2'b00, 5'd8);
    for (int i = 0; i < 4; i++) begin
      total++; if (mem_req !== 1'b1 || wb_valid !== 1'b0) begin
        bad++; $display("FAIL tmo_wait%0d got=%b%b exp=10", i, mem_req, wb_valid); end
      tick();
    end
    total++; if (bus_error !== 1'b1 || wb_valid !== 1'b1 || mem_req !== 1'b0) begin
      bad++; $display("FAIL tmo_flags got=%b%b%b exp=110", bus_error, wb_valid, mem_req); end
    total++; if (wb_data !== 32'h0) begin
      bad++; $display("FAIL tmo_data got=%h exp=0", wb_data); end
    // A stray ack in HOLD must not change the held result.
    ack_after(0, 32'h5555_AAAA);
    total++; if (wb_data !== 32'h0 || bus_error !== 1'b1 || mem_req !== 1'b0) begin
      bad++; $display("FAIL tmo_stray got=%h/%b/%b exp=0/1/0", wb_data, bus_error, mem_req); end
    release_wb();
    total++; if (bus_error !== 1'b0 || wb_valid !== 1'b0) begin
      bad++; $display("FAIL tmo_clear got=%b%b exp=00", bus_error, wb_valid); end
  endtask

  task automatic test_back_to_back();
    issue(2'b00, 2'd1, 2'b00, 5'd3);
    ack_after(0, 32'h0000_AB00);
    // Second load pending while writeback stalls.
    req_valid = 1'b1; load_size = 2'b01; addr_low = 2'd0;
    extension_type = 2'b01; dest_reg = 5'd9;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (req_ready !== 1'b0 || wb_valid !== 1'b1 || mem_req !== 1'b0 ||
                   wb_data !== 32'h0000_00AB || wb_dest !== 5'd3) begin
        bad++; $display("FAIL b2b_stall%0d got=%b%b%b/%h/%0d exp=010/000000ab/3",
                        i, req_ready, wb_valid, mem_req, wb_data, wb_dest); end
      tick();
    end
    wb_ready = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_ready got=%b exp=1", req_ready); end
    tick();
    wb_ready = 1'b0; req_valid = 1'b0;
    total++; if (mem_req !== 1'b1 || wb_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_accept got=%b%b exp=10", mem_req, wb_valid); end
    ack_after(0, 32'h0000_9234);
    total++; if (wb_data !== 32'hFFFF_9234 || wb_dest !== 5'd9) begin
      bad++; $display("FAIL b2b_data got=%h/%0d exp=ffff9234/9", wb_data, wb_dest); end
    release_wb();
  endtask

  task automatic test_reset_mid();
    issue(2'b10, 2'd0, 2'b00, 5'd12);
    total++; if (mem_req !== 1'b1) begin
      bad++; $display("FAIL rmid_memreq got=%b exp=1", mem_req); end
    rst = 1'b1;
    #1;
    total++; if ({mem_req, wb_valid, misaligned, bus_error} !== 4'b0 ||
                 wb_data !== 32'h0 || wb_dest !== 5'h0) begin
      bad++; $display("FAIL rmid_async got=%b/%h/%0d exp=0000/0/0",
                      {mem_req, wb_valid, misaligned, bus_error}, wb_data, wb_dest); end
    #1;
    rst = 1'b0;
    tick();
    ack_after(0, 32'h1234_5678);
    tick();
    total++; if (wb_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL rmid_lateack got=%b%b%b exp=001", wb_valid, mem_req, req_ready); end
  endtask

  initial begin
    test_reset();
    test_sign_byte();
    test_extract();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_data_extractor.md
Name: load_data_extractor

Overview:
- Load-side counterpart of the immediate extension unit. Sits in the MEM stage of the MIPS pipeline, between the load request and the data memory port.
- Issues one data-memory read per load and waits for the memory ack. It then selects the addressed byte, halfword or word and zero- or sign-extends it to 32 bits.
- Holds the result for writeback under a valid/ready handshake.
- Reports misaligned accesses and memory timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in WAIT_MEM before a bus error is flagged. Legal range 1..65535.
- CNT_WIDTH, 16: width of the timeout counter. Must be at least clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  input  1  single system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  MEM stage presents a load
- req_ready  output  1  block can accept a load this cycle
- addr_low  input  2  byte offset of the load address
- load_size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word
- extension_type  input  2  00 zero extension, 01 sign extension, others treated as zero
- dest_reg  input  5  destination register number
- mem_req  output  1  read request to data memory
- mem_ack  input  1  memory read data valid
- mem_rdata  input  32  memory read word, little-endian lanes
- wb_valid  output  1  result available
- wb_ready  input  1  writeback consumes the result
- wb_data  output  32  extracted and extended load data
- wb_dest  output  5  latched dest_reg
- misaligned  output  1  qualified by wb_valid
- bus_error  output  1  qualified by wb_valid

Behaviour:
- FSM states: IDLE, WAIT_MEM, HOLD.
- Reset (asynchronous, any state): state=IDLE; mem_req, wb_valid, misaligned, bus_error = 0; wb_data=0; wb_dest=0; counter=0.
- req_ready = (state==IDLE) | (state==HOLD & wb_ready). This is combinational and allows back-to-back loads.
- Accept: on req_valid & req_ready, latch addr_low, load_size, extension_type and dest_reg.
  - Aligned load: next state WAIT_MEM; counter cleared; mem_req=1 from the next cycle.
  - Misaligned load (MISALIGN_TRAP_EN defined): halfword with addr_low[0]=1, or word with addr_low!=0. Next state HOLD with misaligned=1 and wb_data=0; no memory request is made.
- WAIT_MEM:
  - mem_req held at 1. The counter increments each cycle without ack.
  - On mem_ack: extract from mem_rdata, register into wb_data, then go to HOLD with wb_valid=1 and mem_req=0. Load-to-result latency is 1 cycle after ack.
  - Counter reaching TIMEOUT_CYCLES without ack: go to HOLD with bus_error=1, wb_data=0, mem_req=0.
  - If ack and timeout occur in the same cycle, ack wins.
- Extraction:
  - Byte: mem_rdata[8*addr_low +: 8].
  - Halfword: mem_rdata[16*addr_low[1] +: 16].
  - Word: full 32 bits, no extension.
  - Sign extension replicates bit 7 (byte) or bit 15 (halfword).
- HOLD:
  - wb_valid=1; wb_data, wb_dest, misaligned and bus_error stay stable until wb_ready.
  - On wb_ready with no new accepted load: return to IDLE and clear wb_valid, misaligned and bus_error.
  - On wb_ready with a simultaneous accept: the new load takes effect directly.
- mem_ack outside WAIT_MEM is ignored.
- req_valid in WAIT_MEM, or in HOLD without wb_ready, is not accepted (req_ready=0).
- Reset asserted mid-WAIT_MEM drops mem_req immediately. A late ack after reset is ignored.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: misaligned loads are detected as above. They complete in HOLD with misaligned=1, wb_data=0 and no memory access.
- Undefined: misaligned is tied to 0. Low offset bits are forced aligned: halfword uses addr_low[1] only; word ignores addr_low.

Test Plan:
- Sign-extended byte: load_size=00, addr_low=2, ext=01, mem_rdata=0x12_85_34_56, ack 3 cycles after mem_req -> wb_data=0xFFFFFF85, wb_dest latched, wb_valid one cycle after ack.
- Zero-extended halfword: load_size=01, addr_low=2, ext=00, mem_rdata=0x8001_7FFF -> wb_data=0x00008001. Same with ext=01 -> 0xFFFF8001.
- Misaligned word (macro on): load_size=10, addr_low=1 -> mem_req never asserts; HOLD with misaligned=1, wb_data=0. Macro off: word read proceeds and misaligned=0.
- Timeout: TIMEOUT_CYCLES=4, never ack -> mem_req high 4 cycles, then bus_error=1, wb_valid=1, mem_req=0.
- Backpressure/back-to-back: hold wb_ready=0 for 5 cycles -> outputs stable. Then assert wb_ready with req_valid -> new load accepted the same cycle and mem_req=1 the next cycle.
- Reset mid-WAIT_MEM: assert rst while mem_req=1 -> all outputs 0 asynchronously; a later mem_ack produces no wb_valid.
